// File: rtl/aasd_counter_pkg.sv
// Shared types and helpers for the AASD up/down counter family.
// Latency: n/a (package only). Backpressure: n/a.
// Holds the count-mode enum, the default synchroniser depth and the load clamp.
package aasd_counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam int DEFAULT_SYNC_STAGES = 2;

    // Operands arrive zero-extended from the caller's width.
    function automatic logic [31:0] clamp_load(input logic [31:0] data,
                                               input logic [31:0] max_val);
        return (data > max_val) ? max_val : data;
    endfunction

endpackage

// File: rtl/aasd_reset_sync.sv
// Asynchronous-assert / synchronous-deassert reset synchroniser.
// Latency: deassertion appears on the SYNC_STAGES-th rising edge; assertion is immediate.
// Backpressure: none.
module aasd_reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    output logic aasd_reset
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("aasd_reset_sync: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign aasd_reset = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/aasd_updown_counter.sv
// Loadable up/down counter (wrap or saturate) with terminal-count pulse and AASD reset output.
// Latency: one clock from load/enable sampling to count/tc; backpressure: none.
// Optional sticky overflow flag enabled by defining AASD_COUNTER_STICKY_EN.
module aasd_updown_counter
    import aasd_counter_pkg::*;
#(
    parameter int              WIDTH       = 8,
    parameter longint unsigned MAX_VAL     = (64'd1 << WIDTH) - 64'd1,
    parameter int              SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int              SATURATE    = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic             up_down,
    input  logic [WIDTH-1:0] data,
`ifdef AASD_COUNTER_STICKY_EN
    input  logic             sticky_clr,
    output logic             sticky_ovf,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             aasd_reset
);

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam cnt_mode_e        MODE  = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("aasd_updown_counter: WIDTH must be in 2..32");
    end
    if (MAX_W == '0) begin : g_bad_max
        $error("aasd_updown_counter: MAX_VAL must be non-zero");
    end

    aasd_reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clock      (clock),
        .reset      (reset),
        .aasd_reset (aasd_reset)
    );

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] load_val;
    logic             tc_q, tc_d;
    logic             at_limit;

    always_comb begin
        load_val = WIDTH'(clamp_load(32'(data), 32'(MAX_W)));
        at_limit = up_down ? (count_q == MAX_W) : (count_q == '0);
        count_d  = count_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (enable) begin
            tc_d = at_limit;
            if (at_limit) begin
                // Saturate mode leaves count pinned; tc still fires every enabled cycle.
                if (MODE == CNT_WRAP) begin
                    count_d = up_down ? '0 : MAX_W;
                end
            end else begin
                count_d = up_down ? (count_q + ONE) : (count_q - ONE);
            end
        end
    end

    // Counter flops sit on the synchronised reset so release is glitch-free.
    always_ff @(posedge clock or negedge aasd_reset) begin
        if (!aasd_reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

`ifdef AASD_COUNTER_STICKY_EN
    logic sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_clr ? 1'b0 : (sticky_q | tc_d);
    end

    always_ff @(posedge clock or negedge aasd_reset) begin
        if (!aasd_reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_ovf = sticky_q;
`endif

endmodule

// File: tb/tb_aasd_updown_counter.sv
// Directed bench for aasd_updown_counter: default 8-bit, MAX_VAL=9 wrap and MAX_VAL=9 saturate instances.
module tb_aasd_updown_counter;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic       enable;
    logic       up_down;
    logic [7:0] data;
    logic       sticky_clr;

    logic [7:0] cnt_d, cnt_w, cnt_s;
    logic       tc_d, tc_w, tc_s;
    logic       ar_d, ar_w, ar_s;
    logic       sov_d, sov_w, sov_s;

    int checks = 0;
    int errors = 0;

    aasd_updown_counter u_def (
        .clock      (clk),
        .reset      (rst_n),
        .load       (load),
        .enable     (enable),
        .up_down    (up_down),
        .data       (data),
`ifdef AASD_COUNTER_STICKY_EN
        .sticky_clr (sticky_clr),
        .sticky_ovf (sov_d),
`endif
        .count      (cnt_d),
        .tc         (tc_d),
        .aasd_reset (ar_d)
    );

    aasd_updown_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(0)) u_wrap (
        .clock      (clk),
        .reset      (rst_n),
        .load       (load),
        .enable     (enable),
        .up_down    (up_down),
        .data       (data),
`ifdef AASD_COUNTER_STICKY_EN
        .sticky_clr (sticky_clr),
        .sticky_ovf (sov_w),
`endif
        .count      (cnt_w),
        .tc         (tc_w),
        .aasd_reset (ar_w)
    );

    aasd_updown_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1)) u_sat (
        .clock      (clk),
        .reset      (rst_n),
        .load       (load),
        .enable     (enable),
        .up_down    (up_down),
        .data       (data),
`ifdef AASD_COUNTER_STICKY_EN
        .sticky_clr (sticky_clr),
        .sticky_ovf (sov_s),
`endif
        .count      (cnt_s),
        .tc         (tc_s),
        .aasd_reset (ar_s)
    );

`ifndef AASD_COUNTER_STICKY_EN
    assign sov_d = 1'b0;
    assign sov_w = 1'b0;
    assign sov_s = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        enable     = 1'b1;
        up_down    = 1'b1;
        data       = 8'h00;
        sticky_clr = 1'b0;

        // Reset state and release timing
        #1;
        chk("rst_aasd", 32'(ar_d), 32'd0);
        chk("rst_count", 32'(cnt_d), 32'd0);
        chk("rst_tc", 32'(tc_d), 32'd0);
        #79;
        rst_n = 1'b1;
        tick();
        chk("rel_edge1_aasd", 32'(ar_d), 32'd0);
        chk("rel_edge1_count", 32'(cnt_d), 32'd0);
        tick();
        chk("rel_edge2_aasd", 32'(ar_d), 32'd1);
        chk("rel_edge2_count", 32'(cnt_d), 32'd0);
        tick();
        chk("rel_first_count", 32'(cnt_d), 32'd1);

        // Load has priority over enable
        load = 1'b1; data = 8'hCC;
        tick();
        chk("load_cc", 32'(cnt_d), 32'hCC);
        chk("load_tc", 32'(tc_d), 32'd0);
        load = 1'b0;
        tick();
        chk("up_cd", 32'(cnt_d), 32'hCD);
        tick();
        chk("up_ce", 32'(cnt_d), 32'hCE);

        // Wrap instance: up through MAX_VAL
        load = 1'b1; data = 8'd8;
        tick();
        chk("wrap_load8", 32'(cnt_w), 32'd8);
        load = 1'b0;
        tick();
        chk("wrap_9", 32'(cnt_w), 32'd9);
        chk("wrap_9_tc", 32'(tc_w), 32'd0);
        tick();
        chk("wrap_0", 32'(cnt_w), 32'd0);
        chk("wrap_0_tc", 32'(tc_w), 32'd1);
`ifdef AASD_COUNTER_STICKY_EN
        chk("sticky_set", 32'(sov_w), 32'd1);
`endif
        enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("idle_count", 32'(cnt_w), 32'd0);
        chk("idle_tc", 32'(tc_w), 32'd0);
`ifdef AASD_COUNTER_STICKY_EN
        chk("sticky_hold", 32'(sov_w), 32'd1);
        sticky_clr = 1'b1;
`endif
        // Down from 0 wraps to MAX_VAL
        enable = 1'b1; up_down = 1'b0;
        tick();
        chk("down_wrap_9", 32'(cnt_w), 32'd9);
        chk("down_wrap_tc", 32'(tc_w), 32'd1);
`ifdef AASD_COUNTER_STICKY_EN
        chk("sticky_clr_wins", 32'(sov_w), 32'd0);
        sticky_clr = 1'b0;
`endif
        tick();
        chk("down_8", 32'(cnt_w), 32'd8);
        chk("down_8_tc", 32'(tc_w), 32'd0);

        // Saturate instance: pinned at MAX_VAL, tc every enabled cycle
        load = 1'b1; data = 8'd9; up_down = 1'b1;
        tick();
        chk("sat_load9", 32'(cnt_s), 32'd9);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_hold", 32'(cnt_s), 32'd9);
            chk("sat_tc", 32'(tc_s), 32'd1);
        end
        load = 1'b1; data = 8'd3;
        tick();
        chk("sat_load3", 32'(cnt_s), 32'd3);
        data = 8'd12;
        tick();
        chk("sat_clamp12", 32'(cnt_s), 32'd9);
        chk("def_load12", 32'(cnt_d), 32'd12);
        data = 8'd0;
        tick();
        load = 1'b0; up_down = 1'b0;
        tick();
        chk("sat_low_hold", 32'(cnt_s), 32'd0);
        chk("sat_low_tc", 32'(tc_s), 32'd1);
        chk("def_down_wrap", 32'(cnt_d), 32'hFF);

        // Async reset mid-count
        load = 1'b1; data = 8'h37; up_down = 1'b1;
        tick();
        chk("mid_load37", 32'(cnt_d), 32'h37);
        load = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_async_count", 32'(cnt_d), 32'd0);
        chk("mid_async_aasd", 32'(ar_d), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("rec_edge1_aasd", 32'(ar_d), 32'd0);
        chk("rec_edge1_count", 32'(cnt_d), 32'd0);
        tick();
        chk("rec_edge2_aasd", 32'(ar_d), 32'd1);
        chk("rec_edge2_count", 32'(cnt_d), 32'd0);
        tick();
        chk("rec_count1", 32'(cnt_d), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aasd_updown_counter.md
Name: aasd_updown_counter

Overview:
- Parametrised successor to the team's 8-bit loadable counter with asynchronous-assert/synchronous-deassert (AASD) reset.
- Adds configurable width, modulus, up/down direction, wrap or saturate mode, and a configurable-depth reset synchroniser.
- Adds a registered terminal-count pulse.
- Sits beside control FSMs as a general event/timeout counter; it also supplies the synchronised reset to neighbouring logic.

Parameters:
- WIDTH, 8, counter and data width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, inclusive upper count limit (1..2**WIDTH-1).
- SYNC_STAGES, 2, reset synchroniser depth in flops (2..4).
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  synchronous parallel load strobe.
- enable  in  1  count enable.
- up_down  in  1  1 = count up, 0 = count down.
- data  in  WIDTH  load value.
- count  out  WIDTH  registered count.
- tc  out  1  registered terminal-count pulse.
- aasd_reset  out  1  synchronised active-low reset for downstream logic.

Behaviour:
- Reset synchroniser
  - reset low asserts aasd_reset low immediately, without waiting for a clock edge.
  - After reset rises, aasd_reset goes high on the SYNC_STAGES-th rising clock edge. The chain shifts in 1 and is cleared asynchronously by reset.
- Reset state
  - All counter flops are cleared asynchronously by aasd_reset, not by reset directly.
  - Reset values: count = 0, tc = 0, aasd_reset = 0.
  - count ignores load and enable until aasd_reset is high.
  - Reset asserted mid-count clears count asynchronously in the same instant.
- Priority per rising edge: aasd_reset low > load > enable > hold.
- load = 1
  - count <= data when data <= MAX_VAL.
  - count <= MAX_VAL when data > MAX_VAL (clamp).
  - enable is ignored. tc <= 0.
- enable = 1, load = 0, up_down = 1
  - count < MAX_VAL: count <= count + 1.
  - count == MAX_VAL: wrap to 0, or hold at MAX_VAL when SATURATE = 1.
- enable = 1, load = 0, up_down = 0
  - count > 0: count <= count - 1.
  - count == 0: wrap to MAX_VAL, or hold at 0 when SATURATE = 1.
- Terminal count
  - tc <= 1 for exactly one cycle on the edge where an enabled step starts at the limit in the current direction (MAX_VAL going up, 0 going down).
  - This applies in both modes. In saturate mode tc repeats every enabled cycle while pinned at the limit.
- Latency: one clock from load/enable sampling to count and tc update.
- Idle: enable = 0 and load = 0 holds count and drives tc <= 0.
- Direction change: up_down is sampled per cycle with no pipeline.
- Arithmetic: all arithmetic is WIDTH bits. Comparisons use MAX_VAL truncated to WIDTH.
- Elaboration errors: MAX_VAL = 0, or SYNC_STAGES < 2.

Optional Feature:
- Macro: AASD_COUNTER_STICKY_EN.
- When defined, add port sticky_clr (in, 1) and port sticky_ovf (out, 1).
- sticky_ovf sets on any cycle tc would be 1, and stays high until sticky_clr = 1 or reset.
- Clear has priority over a simultaneous set.
- Reset value of sticky_ovf is 0.
- When undefined, neither port nor its logic exists, and behaviour is otherwise identical.

Decomposition:
- Shared package aasd_counter_pkg holds:
  - typedef cnt_mode_e {CNT_WRAP, CNT_SAT}.
  - Constant DEFAULT_SYNC_STAGES = 2.
  - Helper function clamp_load(data, max).
- Sub-module aasd_reset_sync (parameter SYNC_STAGES; ports clock, reset, aasd_reset).
  - Instantiated once.
  - Reusable by other blocks needing AASD reset.

Test Plan:
- Reset release (WIDTH=8, SYNC_STAGES=2): reset held low 80 ns, then released → aasd_reset high on the 2nd rising edge; count = 0 until then; enable = 1 is ignored before that edge.
- Load priority: load = 1, enable = 1, data = 8'hCC → count = 8'hCC next edge, tc = 0. Deassert load with enable = 1, up_down = 1 → count = 8'hCD, then 8'hCE.
- Wrap up and down (MAX_VAL=9, SATURATE=0):
  - Load 8, count up → 9, then 0 with tc = 1 for one cycle.
  - Down from 0 → 9 with tc = 1.
- Saturate (MAX_VAL=9, SATURATE=1): hold at 9 for 3 enabled cycles → count stays 9, tc = 1 on each of the 3 cycles. Load 12 → count = 9 (clamp).
- Async reset mid-count: assert reset between edges at count = 8'h37 → count = 0 and aasd_reset = 0 before the next edge; recovery as in the reset-release scenario.
- AASD_COUNTER_STICKY_EN defined:
  - Wrap event → sticky_ovf = 1 and remains set across 5 idle cycles.
  - sticky_clr = 1 coincident with a wrap → sticky_ovf = 0.
